// File: rtl/usr_param_burst.sv
// rtl/usr_param_burst.sv - parametrised universal shift register with N-step burst engine
module usr_param_burst #(
  parameter int WIDTH = 8,
  parameter int CW    = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic             data_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [2:0]       burst_mode,
  input  logic [CW-1:0]    burst_count,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out_r,
  output logic             serial_out_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_LOAD = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] apply_op(input logic [2:0]       op,
                                                input logic [WIDTH-1:0] cur,
                                                input logic             din,
                                                input logic [WIDTH-1:0] pin);
    logic [WIDTH-1:0] r;
    r = cur;
    case (op)
      OP_SHR:  r = {din, cur[WIDTH-1:1]};
      OP_LOAD: r = pin;
      OP_ROR:  r = {cur[0], cur[WIDTH-1:1]};
      OP_SHL:  r = {cur[WIDTH-2:0], din};
      OP_ROL:  r = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  r = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: r = cur;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Load and reserved codes make no sense repeated, so they burst as hold.
          if (burst_mode == OP_HOLD || burst_mode == OP_LOAD || burst_mode == 3'b111)
            op_d = OP_HOLD;
          else
            op_d = burst_mode;
          cnt_d = burst_count;
          if (burst_count != '0) state_d = RUN;
          else                   done_d  = 1'b1;
        end else begin
          q_d = apply_op(mode, q_q, data_in, parallel_in);
        end
      end
      RUN: begin
        q_d   = apply_op(op_q, q_q, data_in, parallel_in);
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  assign Q            = q_q;
  assign serial_out_r = q_q[0];
  assign serial_out_l = q_q[WIDTH-1];
  assign busy         = (state_q == RUN);
  assign done         = done_q;

endmodule
